// File: rtl/mvb_split_dispatcher_if.sv
// Purpose: bundles the MVB header input, enable mask and formatted MVB output of the split dispatcher.
// Latency: none (wires only).
// Backpressure: carries both src/dst ready pairs; the slave side drives RX_DST_RDY and the TX bus.
interface mvb_split_dispatcher_if #(
    parameter int MVB_ITEMS        = 2,
    parameter int HDR_WIDTH        = 128,
    parameter int SPLITTER_OUTPUTS = 4
);
    localparam int SWITCH_WIDTH = (SPLITTER_OUTPUTS > 1) ? $clog2(SPLITTER_OUTPUTS) : 1;
    localparam int ITEM_WIDTH   = HDR_WIDTH + SWITCH_WIDTH + 1;

    logic [MVB_ITEMS*HDR_WIDTH-1:0]  RX_DATA;
    logic [MVB_ITEMS-1:0]            RX_PAYLOAD;
    logic [MVB_ITEMS-1:0]            RX_VLD;
    logic                            RX_SRC_RDY;
    logic                            RX_DST_RDY;
    logic [SPLITTER_OUTPUTS-1:0]     OUT_ENABLE;
    logic [MVB_ITEMS*ITEM_WIDTH-1:0] TX_DATA;
    logic [MVB_ITEMS-1:0]            TX_VLD;
    logic                            TX_SRC_RDY;
    logic                            TX_DST_RDY;

    // Producer of headers and consumer of dispatched items.
    modport master (
        output RX_DATA, RX_PAYLOAD, RX_VLD, RX_SRC_RDY, OUT_ENABLE, TX_DST_RDY,
        input  RX_DST_RDY, TX_DATA, TX_VLD, TX_SRC_RDY
    );

    // The dispatcher itself.
    modport slave (
        input  RX_DATA, RX_PAYLOAD, RX_VLD, RX_SRC_RDY, OUT_ENABLE, TX_DST_RDY,
        output RX_DST_RDY, TX_DATA, TX_VLD, TX_SRC_RDY
    );
endinterface

// File: rtl/mvb_split_dispatcher.sv
// Purpose: tags each valid MVB header with a round-robin splitter output index over the enabled outputs.
// Latency: 1 cycle from RX accept to TX_SRC_RDY, one word per cycle sustained.
// Backpressure: RX_DST_RDY = (TX_DST_RDY | ~TX_SRC_RDY) & (OUT_ENABLE != 0); TX holds while stalled.
module mvb_split_dispatcher #(
    parameter int MVB_ITEMS        = 2,
    parameter int HDR_WIDTH        = 128,
    parameter int SPLITTER_OUTPUTS = 4
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    mvb_split_dispatcher_if.slave bus
);
    localparam int SWITCH_WIDTH = (SPLITTER_OUTPUTS > 1) ? $clog2(SPLITTER_OUTPUTS) : 1;
    localparam int ITEM_WIDTH   = HDR_WIDTH + SWITCH_WIDTH + 1;

    logic [SWITCH_WIDTH-1:0]           ptr;
    logic [SWITCH_WIDTH-1:0]           ptr_next;
    logic [MVB_ITEMS*SWITCH_WIDTH-1:0] sw;
    logic [MVB_ITEMS*ITEM_WIDTH-1:0]   tx_data_next;
    logic [MVB_ITEMS*ITEM_WIDTH-1:0]   tx_data;
    logic [MVB_ITEMS-1:0]              tx_vld;
    logic                              tx_src_rdy;
    logic                              accept;

    // Ready ignores RX_SRC_RDY; an all-zero enable mask blocks input but TX still drains.
    assign bus.RX_DST_RDY = (bus.TX_DST_RDY | ~tx_src_rdy) & (|bus.OUT_ENABLE);
    assign accept         = bus.RX_SRC_RDY & bus.RX_DST_RDY;

    // Walk the items in ascending order, each valid one taking the next enabled output from the
    // working pointer; wrap is done explicitly so non power-of-2 output counts never alias.
    always_comb begin
        int  wp;
        int  idx;
        int  sel;
        logic found;
        logic [SWITCH_WIDTH-1:0] idx_s;
        wp    = int'(ptr);
        idx   = 0;
        sel   = 0;
        found = 1'b0;
        idx_s = '0;
        sw    = '0;
        for (int i = 0; i < MVB_ITEMS; i++) begin
            if (bus.RX_VLD[i]) begin
                found = 1'b0;
                sel   = wp;
                for (int j = 0; j < SPLITTER_OUTPUTS; j++) begin
                    idx = wp + j;
                    if (idx >= SPLITTER_OUTPUTS) begin
                        idx = idx - SPLITTER_OUTPUTS;
                    end
                    idx_s = SWITCH_WIDTH'(idx);
                    if (!found && bus.OUT_ENABLE[idx_s]) begin
                        found = 1'b1;
                        sel   = idx;
                    end
                end
                if (found) begin
                    sw[i*SWITCH_WIDTH +: SWITCH_WIDTH] = SWITCH_WIDTH'(sel);
                    wp = (sel == SPLITTER_OUTPUTS - 1) ? 0 : sel + 1;
                end
            end
        end
        ptr_next = SWITCH_WIDTH'(wp);
    end

    // Assemble each output item as {payload flag, switch, header}.
    always_comb begin
        tx_data_next = '0;
        for (int i = 0; i < MVB_ITEMS; i++) begin
            tx_data_next[i*ITEM_WIDTH +: ITEM_WIDTH] = {bus.RX_PAYLOAD[i],
                                                        sw[i*SWITCH_WIDTH +: SWITCH_WIDTH],
                                                        bus.RX_DATA[i*HDR_WIDTH +: HDR_WIDTH]};
        end
    end

    // Output register and pointer: load on accept (also covers consume+accept), clear valid on drain.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            ptr        <= '0;
            tx_data    <= '0;
            tx_vld     <= '0;
            tx_src_rdy <= 1'b0;
        end else if (accept) begin
            ptr        <= ptr_next;
            tx_data    <= tx_data_next;
            tx_vld     <= bus.RX_VLD;
            tx_src_rdy <= 1'b1;
        end else if (bus.TX_DST_RDY) begin
            tx_src_rdy <= 1'b0;
        end
    end

    assign bus.TX_DATA    = tx_data;
    assign bus.TX_VLD     = tx_vld;
    assign bus.TX_SRC_RDY = tx_src_rdy;

endmodule

// File: tb/tb_mvb_split_dispatcher.sv
// Purpose: self-checking bench for mvb_split_dispatcher with a vector table, scoreboard and corner sequences.
// Latency: expects TX one cycle after every accept.
// Backpressure: exercises TX_DST_RDY stalls, all-zero enable masks and reset with a word held in TX.
module tb_mvb_split_dispatcher;
    localparam int ITEMS = 2;
    localparam int HW    = 128;
    localparam int OUTS  = 4;
    localparam int SWW   = 2;
    localparam int IW    = HW + SWW + 1;
    localparam int TXW   = ITEMS * IW;

    typedef struct {
        logic [TXW-1:0]   data;
        logic [ITEMS-1:0] vld;
    } exp_t;

    typedef struct {
        logic [1:0] vld;
        logic [3:0] en;
        logic [1:0] s0;
        logic [1:0] s1;
    } vec_t;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   run = 0;
    int   max_run = 0;
    exp_t sb[$];

    mvb_split_dispatcher_if #(.MVB_ITEMS(ITEMS), .HDR_WIDTH(HW), .SPLITTER_OUTPUTS(OUTS)) bus ();

    mvb_split_dispatcher #(.MVB_ITEMS(ITEMS), .HDR_WIDTH(HW), .SPLITTER_OUTPUTS(OUTS)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [TXW-1:0] act, input logic [TXW-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [HW-1:0] rh();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [TXW-1:0] mk(input logic [HW-1:0] h0, input logic [HW-1:0] h1,
                                          input logic [1:0] pay, input logic [1:0] s0,
                                          input logic [1:0] s1);
        logic [IW-1:0] i0;
        logic [IW-1:0] i1;
        i0 = {pay[0], s0, h0};
        i1 = {pay[1], s1, h1};
        return {i1, i0};
    endfunction

    // Scoreboard: pop and compare every consumed TX word; track the longest run of valid TX cycles.
    always @(negedge CLK) begin
        if (RESET_N && bus.TX_SRC_RDY && bus.TX_DST_RDY) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got word %0h, expected no word", bus.TX_DATA);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_data", bus.TX_DATA, e.data);
                check("sb_vld", TXW'(bus.TX_VLD), TXW'(e.vld));
            end
        end
        run     = bus.TX_SRC_RDY ? run + 1 : 0;
        max_run = (run > max_run) ? run : max_run;
    end

    // Offer one word, push its expectation when accepted, return 1ns after the accepting edge.
    task automatic send(input logic [HW-1:0] h0, input logic [HW-1:0] h1, input logic [1:0] pay,
                        input logic [1:0] vld, input logic [3:0] en,
                        input logic [1:0] s0, input logic [1:0] s1);
        exp_t e;
        bit   done;
        done              = 1'b0;
        bus.RX_DATA       = {h1, h0};
        bus.RX_PAYLOAD    = pay;
        bus.RX_VLD        = vld;
        bus.OUT_ENABLE    = en;
        bus.RX_SRC_RDY    = 1'b1;
        e.data            = mk(h0, h1, pay, s0, s1);
        e.vld             = vld;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge CLK);
            if (bus.RX_DST_RDY) begin
                sb.push_back(e);
                done = 1'b1;
            end
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL send_timeout: got no accept in 50 cycles, expected accept");
        end else begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic idle();
        bus.RX_SRC_RDY = 1'b0;
        bus.RX_VLD     = '0;
    endtask

    task automatic cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge CLK);
        end
        #1;
    endtask

    vec_t vt[13];

    initial begin
        logic [HW-1:0] a0, a1, b0, b1;
        bit drained;

        // Continuation of the pointer after the opening three words (PTR = 2).
        vt[0]  = '{2'b11, 4'b1111, 2'd2, 2'd3};
        vt[1]  = '{2'b11, 4'b0101, 2'd0, 2'd2};
        vt[2]  = '{2'b11, 4'b0101, 2'd0, 2'd2};
        vt[3]  = '{2'b11, 4'b1000, 2'd3, 2'd3};
        vt[4]  = '{2'b01, 4'b1111, 2'd0, 2'd0};
        vt[5]  = '{2'b10, 4'b1111, 2'd0, 2'd1};
        vt[6]  = '{2'b11, 4'b1111, 2'd2, 2'd3};
        vt[7]  = '{2'b11, 4'b1010, 2'd1, 2'd3};
        vt[8]  = '{2'b00, 4'b1111, 2'd0, 2'd0};
        vt[9]  = '{2'b11, 4'b0010, 2'd1, 2'd1};
        vt[10] = '{2'b01, 4'b1111, 2'd2, 2'd0};
        vt[11] = '{2'b11, 4'b1111, 2'd3, 2'd0};
        vt[12] = '{2'b10, 4'b1001, 2'd0, 2'd3};

        bus.RX_DATA    = '0;
        bus.RX_PAYLOAD = '0;
        bus.RX_VLD     = '0;
        bus.RX_SRC_RDY = 1'b0;
        bus.OUT_ENABLE = 4'b1111;
        bus.TX_DST_RDY = 1'b1;
        cycles(2);
        @(negedge CLK);
        check("rst_tx_src_rdy", TXW'(bus.TX_SRC_RDY), '0);
        check("rst_tx_vld", TXW'(bus.TX_VLD), '0);
        check("rst_tx_data", bus.TX_DATA, '0);
        check("rst_rx_dst_rdy", TXW'(bus.RX_DST_RDY), TXW'(1'b1));
        @(posedge CLK);
        #1 RESET_N = 1'b1;
        max_run = 0;

        // Three back-to-back words: (0,1), (2,3), (0,1), TX valid for exactly 3 cycles.
        send(rh(), rh(), 2'b10, 2'b11, 4'b1111, 2'd0, 2'd1);
        check("latency_1", TXW'(bus.TX_SRC_RDY), TXW'(1'b1));
        send(rh(), rh(), 2'b01, 2'b11, 4'b1111, 2'd2, 2'd3);
        send(rh(), rh(), 2'b11, 2'b11, 4'b1111, 2'd0, 2'd1);
        idle();
        cycles(3);
        check("b2b_run", TXW'(max_run), TXW'(3));

        for (int v = 0; v < 13; v++) begin
            send(rh(), rh(), 2'($urandom_range(0, 3)), vt[v].vld, vt[v].en, vt[v].s0, vt[v].s1);
        end
        idle();
        cycles(2);

        // All outputs disabled: no accept for 4 cycles, TX drains, pointer (2) preserved.
        send(rh(), rh(), 2'b00, 2'b11, 4'b1111, 2'd0, 2'd1);
        bus.OUT_ENABLE = 4'b0000;
        bus.RX_VLD     = 2'b11;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            check("en0_rx_dst_rdy", TXW'(bus.RX_DST_RDY), '0);
        end
        check("en0_tx_drained", TXW'(bus.TX_SRC_RDY), '0);
        @(posedge CLK);
        #1;
        send(rh(), rh(), 2'b11, 2'b11, 4'b1111, 2'd2, 2'd3);
        idle();
        cycles(2);

        // Downstream stall for 5 cycles with a second word waiting.
        a0 = rh(); a1 = rh(); b0 = rh(); b1 = rh();
        bus.TX_DST_RDY = 1'b0;
        send(a0, a1, 2'b01, 2'b11, 4'b1111, 2'd0, 2'd1);
        bus.RX_DATA    = {b1, b0};
        bus.RX_PAYLOAD = 2'b10;
        bus.RX_VLD     = 2'b11;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            check("stall_rx_dst_rdy", TXW'(bus.RX_DST_RDY), '0);
            check("stall_tx_data", bus.TX_DATA, mk(a0, a1, 2'b01, 2'd0, 2'd1));
            check("stall_tx_vld", TXW'(bus.TX_VLD), TXW'(2'b11));
        end
        @(posedge CLK);
        #1 bus.TX_DST_RDY = 1'b1;
        send(b0, b1, 2'b10, 2'b11, 4'b1111, 2'd2, 2'd3);
        idle();
        cycles(2);

        // Reset while a word sits in TX with PTR = 3; the word is discarded.
        bus.TX_DST_RDY = 1'b0;
        send(rh(), rh(), 2'b11, 2'b01, 4'b0100, 2'd2, 2'd0);
        idle();
        check("pre_rst_tx_src_rdy", TXW'(bus.TX_SRC_RDY), TXW'(1'b1));
        RESET_N = 1'b0;
        @(posedge CLK);
        #1 RESET_N = 1'b1;
        sb.delete();
        @(negedge CLK);
        check("post_rst_tx_src_rdy", TXW'(bus.TX_SRC_RDY), '0);
        check("post_rst_tx_vld", TXW'(bus.TX_VLD), '0);
        check("post_rst_tx_data", bus.TX_DATA, '0);
        @(posedge CLK);
        #1 bus.TX_DST_RDY = 1'b1;
        send(rh(), rh(), 2'b01, 2'b11, 4'b1111, 2'd0, 2'd1);
        idle();

        drained = 1'b0;
        for (int c = 0; c < 20 && !drained; c++) begin
            @(posedge CLK);
            drained = (sb.size() == 0);
        end
        cycles(1);
        check("sb_empty", TXW'(sb.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mvb_split_dispatcher.md
Name: mvb_split_dispatcher

Overview:
- Upstream stage of the MFB splitter.
- Takes MVB header words (up to MVB_ITEMS headers per word) and gives each valid header a splitter output index (switch), using round-robin over the currently enabled outputs.
- Emits MVB items formatted as {payload flag, switch, header}, which is exactly the splitter's MVB input item.
- One registered output stage with full src/dst ready backpressure.

Parameters:
- MVB_ITEMS, 2, header items per MVB word.
- HDR_WIDTH, 128, header width in bits.
- SPLITTER_OUTPUTS, 4, number of splitter outputs; must be >= 2; need not be a power of 2.
- SWITCH_WIDTH, log2 ceiling of SPLITTER_OUTPUTS, width of the switch field (derived, not overridable).

Ports:
- CLK  in  1  clock.
- RESET_N  in  1  reset; synchronous, active-low.
- RX_DATA  in  MVB_ITEMS*HDR_WIDTH  headers; item i occupies bits [i*HDR_WIDTH +: HDR_WIDTH].
- RX_PAYLOAD  in  MVB_ITEMS  per-item flag: the header has an MFB payload.
- RX_VLD  in  MVB_ITEMS  per-item valid.
- RX_SRC_RDY  in  1  word valid.
- RX_DST_RDY  out  1  word accepted.
- OUT_ENABLE  in  SPLITTER_OUTPUTS  bit k=1 means output k may receive traffic.
- TX_DATA  out  MVB_ITEMS*(HDR_WIDTH+SWITCH_WIDTH+1)  output items. Within item i:
  - bits [HDR_WIDTH-1:0] = header;
  - next SWITCH_WIDTH bits = switch;
  - MSB = payload flag.
- TX_VLD  out  MVB_ITEMS  per-item valid.
- TX_SRC_RDY  out  1  output word valid.
- TX_DST_RDY  in  1  downstream ready.

Behaviour:
- Transfer rules:
  - An RX word is accepted when RX_SRC_RDY=1 and RX_DST_RDY=1.
  - A TX word is consumed when TX_SRC_RDY=1 and TX_DST_RDY=1.
- RX_DST_RDY = (TX_DST_RDY or not TX_SRC_RDY) and (OUT_ENABLE != 0). It is combinational, with no dependency on RX_SRC_RDY.
- Latency: exactly 1 cycle from RX accept to TX_SRC_RDY=1. Throughput is one word per cycle while TX_DST_RDY=1.
- Output register behaviour:
  - On accept: load TX_DATA headers and payload flags verbatim, TX_VLD=RX_VLD, computed switches, TX_SRC_RDY=1.
  - TX_SRC_RDY=1 after accept even if RX_VLD=0; an empty word passes through.
  - Consumed with no new accept: TX_SRC_RDY=0.
  - While TX_SRC_RDY=1 and TX_DST_RDY=0: TX_DATA, TX_VLD and TX_SRC_RDY hold stable.
- Round-robin pointer PTR:
  - Range 0..SPLITTER_OUTPUTS-1; reset value 0.
  - Items are processed in ascending index i within the accepted word.
  - If RX_VLD[i]=1: switch = first k, searched cyclically starting at the current pointer, with OUT_ENABLE[k]=1. The working pointer then becomes (k+1) mod SPLITTER_OUTPUTS.
  - If RX_VLD[i]=0: the switch field of that item is 0 and the pointer is unchanged.
  - PTR is registered with the final working pointer only on accept.
  - Wrap is explicit at SPLITTER_OUTPUTS-1 -> 0. No binary overflow is allowed when SPLITTER_OUTPUTS is not a power of 2.
- OUT_ENABLE:
  - Sampled combinationally in the accept cycle only; later changes do not alter already registered items.
  - All zeros: no accept (RX_DST_RDY=0) and PTR holds. The TX stage still drains normally.
  - A single enabled output k: every valid item gets switch k.
  - A disabled output is never selected. If PTR points at a disabled output, the search skips forward.
- Payload flag: copied unmodified; it does not influence the switch choice.
- Reset (RESET_N=0 at a clock edge):
  - Next cycle: TX_SRC_RDY=0, TX_VLD=0, TX_DATA=0, PTR=0.
  - RX_DST_RDY follows its equation, with TX_SRC_RDY=0.
  - A word held in TX at reset is discarded.
  - No accept occurs in a cycle where RESET_N=0.
- Simultaneous consume and accept in one cycle: the new word replaces the old with no bubble.

Test Plan:
- Common conditions, unless a line says otherwise: SPLITTER_OUTPUTS=4, MVB_ITEMS=2, OUT_ENABLE=1111, TX_DST_RDY=1.
- Three back-to-back words, RX_VLD=11 -> switches (item0,item1) = (0,1), (2,3), (0,1). TX_SRC_RDY is high for 3 consecutive cycles, starting 1 cycle after the first accept.
- OUT_ENABLE=0101, two words, RX_VLD=11 -> switches (0,2), (0,2). Output 1 and output 3 are never used.
- RX_VLD=01, then 10, then 11 -> word1 item0=0; word2 item1=1, with item0 switch 0 and TX_VLD=10; word3 (2,3).
- After one word with VLD=11 (PTR=2), set OUT_ENABLE=0000 and hold RX_SRC_RDY=1 for 4 cycles -> RX_DST_RDY=0 and no new TX. Then set OUT_ENABLE=1111 -> the next word gets (2,3).
- TX_DST_RDY=0 for 5 cycles while words are pending -> TX_DATA and TX_VLD stable, RX_DST_RDY=0. On release, words appear in order with no loss or duplication, and headers and payload flags match the input bit-exactly.
- Assert RESET_N=0 for 1 cycle while TX_SRC_RDY=1 and PTR=3 -> next cycle TX_SRC_RDY=0. The first word after reset gets switches (0,1).
